// File: rtl/smul_arb_pkg.sv
// Shared widths and arithmetic helpers for the smul request arbiter.
// Contents: AIN_W/BIN_W/POUT_W/PROD_W, smul() (12b signed x 7b unsigned -> 9b), round_sat8().
// No state; both helpers are pure combinational functions.
package smul_arb_pkg;

  localparam int AIN_W  = 12;
  localparam int BIN_W  = 7;
  localparam int POUT_W = 9;
  localparam int PROD_W = AIN_W + BIN_W + 1;
  localparam int SHIFT  = 9;

  // Bits [17:9] of the full signed product. The multiplier gets a zero MSB so
  // it is treated as a non-negative value in a signed multiply.
  function automatic logic [POUT_W-1:0] smul(input logic [AIN_W-1:0] a,
                                             input logic [BIN_W-1:0] b);
    logic signed [PROD_W-1:0] sa;
    logic signed [PROD_W-1:0] sb;
    logic signed [PROD_W-1:0] p;
    sa = PROD_W'($signed(a));
    sb = PROD_W'({1'b0, b});
    p  = sa * sb;
    return POUT_W'(p >>> SHIFT);
  endfunction

  // Drop the LSB with round-half-up, then clamp to [-128,127]. Only the
  // upward direction can overflow (127 + 1), so only that side is clamped.
  // The 9b result is the 8b value sign-extended.
  function automatic logic [POUT_W-1:0] round_sat8(input logic [POUT_W-1:0] pout);
    logic signed [POUT_W-1:0] s;
    s = $signed({pout[8], pout[8:1]}) + $signed({8'd0, pout[0]});
    if (s > 9'sd127) s = 9'sd127;
    return s;
  endfunction

endpackage

// File: rtl/smul_arbiter_rr_arbiter.sv
// Round-robin grant picker for the smul arbiter; owns the rotating pointer.
// Ports: req (valid vector), advance (grant is taken this cycle) -> gnt (one-hot), gnt_id.
// Latency: grant is combinational; pointer moves to gnt_id+1 only when advance and a request exists.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] ptr;
  logic           found;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

endmodule

// File: rtl/smul_arbiter.sv
// Shares one 12b-signed x 7b-unsigned -> 9b multiplier among NREQ round-robin requesters.
// Latency 2 cycles from request handshake to res_valid; 1 product/cycle at full rate.
// Backpressure: result held while res_valid&!res_ready; operand stage then holds and req_ready drops to 0.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_ain/req_bin per requester;
//        res_valid/res_ready/res_id/res_data result port; busy = any stage occupied.
// Build option: SMUL_ROUND_EN rounds and saturates the product to 8b (sign-extended to 9b).
module smul_arbiter
  import smul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*AIN_W-1:0] req_ain,
  input  logic [NREQ*BIN_W-1:0] req_bin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [POUT_W-1:0]     res_data,
  output logic                  busy
);

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic              accept;
  logic              res_load;

  logic              op_vld;
  logic [AIN_W-1:0]  op_ain;
  logic [BIN_W-1:0]  op_bin;
  logic [IDW-1:0]    op_id;

  logic [AIN_W-1:0]  mux_ain;
  logic [BIN_W-1:0]  mux_bin;
  logic [POUT_W-1:0] pout;
  logic [POUT_W-1:0] res_next;

  // Result register takes the operand stage whenever it is empty or draining.
  assign res_load = op_vld & (~res_valid | res_ready);
  // Operand stage can take a new request when empty or emptying this cycle.
  assign accept   = ~op_vld | res_load;

  assign req_ready = accept ? gnt : '0;
  assign busy      = op_vld | res_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // One-hot AND-OR mux; gnt has at most one bit set.
  always_comb begin
    mux_ain = '0;
    mux_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mux_ain = req_ain[AIN_W*i +: AIN_W];
        mux_bin = req_bin[BIN_W*i +: BIN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_ain <= '0;
      op_bin <= '0;
      op_id  <= '0;
    end else if (accept) begin
      op_vld <= |gnt;
      if (|gnt) begin
        op_ain <= mux_ain;
        op_bin <= mux_bin;
        op_id  <= gnt_id;
      end
    end
  end

  assign pout = smul(op_ain, op_bin);

`ifdef SMUL_ROUND_EN
  assign res_next = round_sat8(pout);
`else
  assign res_next = pout;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else if (res_load) begin
      res_valid <= 1'b1;
      res_id    <= op_id;
      res_data  <= res_next;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smul_arbiter.sv
// Self-checking bench for smul_arbiter: table of single-request vectors, then
// full-rate, stall, and mid-flight reset sequences checked by a cycle model and scoreboard.
// Build option SMUL_ROUND_EN selects the rounded expectations.
module tb_smul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*12-1:0] req_ain;
  logic [NREQ*7-1:0] req_bin;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [8:0]        res_data;
  logic              busy;

  smul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ain   (req_ain),
    .req_bin   (req_bin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product: floor(a*b / 512), optionally rounded half-up and clamped.
  function automatic logic [8:0] model(input logic [11:0] a, input logic [6:0] b);
    int p;
    int q;
    p = int'($signed(a)) * int'({25'd0, b});
    q = p >>> 9;
`ifdef SMUL_ROUND_EN
    q = (q + 1) >>> 1;
    if (q > 127) q = 127;
`endif
    return 9'(q);
  endfunction

  function automatic logic [NREQ-1:0] rr_pick(input int ptr, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g == '0 && v[(ptr + k) % NREQ]) g[(ptr + k) % NREQ] = 1'b1;
    end
    return g;
  endfunction

  typedef struct {
    logic [IDW-1:0] id;
    logic [8:0]     data;
  } sb_t;
  sb_t sb[$];

  // Cycle model of occupancy and pointer, plus scoreboard, evaluated mid-cycle.
  initial begin
    bit              m_op;
    bit              m_res;
    int              m_ptr;
    bit              stall;
    bit              rload;
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] hs;
    sb_t             e;
    m_op = 0; m_res = 0; m_ptr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_op = 0; m_res = 0; m_ptr = 0;
        sb.delete();
      end else begin
        stall   = m_op && m_res && !res_ready;
        exp_gnt = stall ? '0 : rr_pick(m_ptr, req_valid);
        chk("req_ready", 32'(req_ready), 32'(exp_gnt));
        chk("res_valid", 32'(res_valid), 32'(m_res));
        chk("busy", 32'(busy), 32'(m_op | m_res));
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected", 32'(res_valid), 32'(0));
          end else begin
            e = sb.pop_front();
            n_pop++;
            chk("sb_id", 32'(res_id), 32'(e.id));
            chk("sb_data", 32'(res_data), 32'(e.data));
          end
        end
        hs = req_valid & req_ready;
        for (int j = 0; j < NREQ; j++) begin
          if (hs[j]) begin
            e.id   = IDW'(j);
            e.data = model(req_ain[12*j +: 12], req_bin[7*j +: 7]);
            sb.push_back(e);
          end
        end
        rload = m_op && (!m_res || res_ready);
        m_res = rload || (m_res && !res_ready);
        m_op  = (exp_gnt != '0) || (m_op && !rload);
        for (int j = 0; j < NREQ; j++) if (exp_gnt[j]) m_ptr = (j + 1) % NREQ;
      end
    end
  end

  typedef struct {
    logic [11:0] ain;
    logic [6:0]  bin;
    logic [8:0]  raw;
    logic [8:0]  rnd;
  } vec_t;
  vec_t tbl[8];

  logic [8:0]     held_d;
  logic [IDW-1:0] held_i;
  bit             held_ok;

  task automatic rand_port(input int i);
    req_ain[12*i +: 12] = 12'($urandom);
    req_bin[7*i +: 7]   = 7'($urandom_range(0, 63));
  endtask

  // n cycles with fixed res_ready; operands of a port change only after it was accepted.
  task automatic run(input int n, input logic rdy);
    logic [NREQ-1:0] hs;
    res_ready = rdy;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!rdy && res_valid) begin
        if (!held_ok) begin
          held_d = res_data; held_i = res_id; held_ok = 1;
        end else begin
          chk("held_data", 32'(res_data), 32'(held_d));
          chk("held_id", 32'(res_id), 32'(held_i));
        end
      end
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) rand_port(i);
    end
  endtask

  initial begin
    logic [NREQ-1:0] oh;
    logic [8:0]      expd;
    int              k;
    int              pop0;

    tbl[0] = '{12'd1024, 7'd64,  9'h080, 9'h040};
    tbl[1] = '{12'hC00,  7'd64,  9'h180, 9'h1C0};
    tbl[2] = '{12'd768,  7'd1,   9'h001, 9'h001};
    tbl[3] = '{12'h7F8,  7'd64,  9'h0FF, 9'h07F};
    tbl[4] = '{12'hFFF,  7'd1,   9'h1FF, 9'h000};
    tbl[5] = '{12'h800,  7'd63,  9'h104, 9'h182};
    tbl[6] = '{12'd0,    7'd127, 9'h000, 9'h000};
    tbl[7] = '{12'h300,  7'd127, 9'h0BE, 9'h05F};

    rst_n = 0; req_valid = '0; req_ain = '0; req_bin = '0; res_ready = 1; held_ok = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_res_id", 32'(res_id), 32'(0));
    chk("rst_res_data", 32'(res_data), 32'(0));
    @(posedge clk); #1;

    // Single requests, one port at a time, checking the 2-cycle latency.
    for (int i = 0; i < 8; i++) begin
      k = i % NREQ;
`ifdef SMUL_ROUND_EN
      expd = tbl[i].rnd;
`else
      expd = tbl[i].raw;
`endif
      req_ain[12*k +: 12] = tbl[i].ain;
      req_bin[7*k +: 7]   = tbl[i].bin;
      req_valid = '0;
      req_valid[k] = 1'b1;
      oh = '0;
      oh[k] = 1'b1;
      @(negedge clk);
      chk("tbl_gnt", 32'(req_ready), 32'(oh));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("tbl_lat_t1", 32'(res_valid), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_lat_t2", 32'(res_valid), 32'(1));
      chk("tbl_id", 32'(res_id), 32'(k));
      chk("tbl_data", 32'(res_data), 32'(expd));
      @(posedge clk); #1;
    end

    // Full rate, all requesters valid.
    for (int i = 0; i < NREQ; i++) rand_port(i);
    req_valid = '1;
    run(12, 1'b1);

    // Five-cycle consumer stall, then release and drain.
    held_ok = 0;
    run(4, 1'b0);
    @(negedge clk);
    chk("stall_req_ready", 32'(req_ready), 32'(0));
    chk("stall_res_data", 32'(res_data), 32'(held_d));
    @(posedge clk); #1;
    run(10, 1'b1);
    req_valid = '0;
    run(4, 1'b1);
    chk("drain_empty", 32'(sb.size()), 32'(0));

    // Reset with both stages full.
    held_ok = 0;
    req_valid = '1;
    run(3, 1'b0);
    rst_n = 0;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1;
    res_ready = 1;
    for (int i = 0; i < NREQ; i++) rand_port(i);
    req_valid = '1;
    pop0 = n_pop;
    @(negedge clk);
    chk("mrst_res_valid", 32'(res_valid), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_res_id", 32'(res_id), 32'(0));
    chk("mrst_res_data", 32'(res_data), 32'(0));
    chk("mrst_ptr0", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[2] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk("mrst_results", 32'(n_pop - pop0), 32'(2));
    chk("mrst_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
